tt_uio_bus_sched: RTL and testbench
===================================

Name: tt_uio_bus_sched

Overview:
- Schedules the shared 8-bit bidirectional uio pad bus between two internal write requesters and an external read direction.
- Grants are round-robin, with a bounded hold time.
- Between owners the bus is forced tristate for a turnaround gap, so two drivers never overlap.
- Sits between the design datapaths and the uio_out/uio_oe/uio_in pins of the top-level tile.

Parameters:
MAX_HOLD, 16, max consecutive OWN cycles while the other requester is waiting (>=2)
TURN, 1, tristate turnaround cycles after each release (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; low forces release and blocks new grants
req  input  2  bus request, bit i from requester i; level, held for the whole burst
wdata0  input  8  write byte from requester 0
wdata1  input  8  write byte from requester 1
wvalid  input  2  wdataN valid
wready  output  2  byte accepted when wvalid[i]&wready[i]
grant  output  2  one-hot current owner, 0 when no owner
uio_out  output  8  pad output data, registered
uio_oe  output  8  pad enable, all-ones or all-zeros, registered
uio_in  input  8  pad input data
rdata  output  8  uio_in sampled in IDLE
busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - state=IDLE, grant=0, wready=0, uio_out=0, uio_oe=0, rdata=0, busy=0.
  - Round-robin pointer favours requester 0; hold count=0; turn count=0.
- States IDLE, OWN, TURN.
- IDLE:
  - uio_oe=0.
  - rdata<=uio_in every cycle.
  - If ena and req!=0: choose the winner. The pointer side wins if both request; otherwise the sole requester.
  - Next cycle: grant=winner, state=OWN, uio_oe=8'hFF, uio_out=0, hold=0.
  - Latency: req seen at edge N gives grant/oe high after edge N+1 (one cycle).
- OWN (owner g):
  - wready[g]=1 combinationally while state==OWN and no release is pending this cycle.
  - wready[other]=0.
  - An accepted byte appears on uio_out after the next edge and is held until the next accept.
  - hold increments each OWN cycle.
- Release condition, evaluated each OWN cycle:
  - !req[g], or
  - !ena, or
  - (hold==MAX_HOLD-1 and req[other]).
  - If the other side is not requesting, hold saturates at MAX_HOLD-1 and ownership continues indefinitely.
- Release cycle:
  - wready=0, so no byte is accepted.
  - Next edge: grant=0, uio_oe=0, uio_out=0, pointer<=other, state=TURN, turn=0.
- TURN:
  - uio_oe=0, grant=0, wready=0.
  - Lasts exactly TURN cycles, then IDLE.
  - Requests are ignored during TURN.
  - Minimum gap between owners is TURN+1 cycles with oe=0 (TURN cycles plus one IDLE arbitration cycle).
- Invariant: never grant with oe=0 in OWN; never oe=1 outside OWN; grant is always one-hot or zero.
- Simultaneous events:
  - req[g] dropping in the same cycle as wvalid[g]: no accept; release.
  - Both requests arriving in IDLE: pointer decides.
- ena low:
  - In IDLE: no grant.
  - In OWN: release path including TURN.
  - rdata keeps sampling in IDLE regardless of ena.
- rst_n low at any time: all registers clear immediately (asynchronous), including mid-burst and mid-TURN. First grant after reset goes to requester 0 on a tie.

Test Plan:
- Reset, then req=2'b01, three bytes 0xA5, 0x3C, 0xFF with wvalid constant -> grant=01 and uio_oe=0xFF one cycle after req; uio_out shows A5, 3C, FF on consecutive cycles; req drop -> oe=0 next edge, TURN=1 cycle, back to IDLE.
- req=2'b11 from IDLE after reset, both hold req, MAX_HOLD=4 -> requester 0 owns exactly 4 cycles, oe=0 for 1 TURN cycle plus 1 IDLE cycle, then requester 1 owns 4 cycles, then requester 0 again.
- Single requester 1 holding req for 40 cycles with MAX_HOLD=16 -> grant never drops; hold saturates; uio_oe stays 0xFF all 40 cycles.
- IDLE, uio_in=0x5A then 0xC3 -> rdata follows with one-cycle latency; in OWN, rdata holds its last IDLE value.
- ena dropped mid-OWN -> wready=0 that cycle; oe=0 and grant=0 next edge; with ena still low no new grant despite req=2'b11.
- rst_n pulsed low for a partial cycle mid-burst -> uio_oe, grant and uio_out clear asynchronously before the next clock edge; after release, tie goes to requester 0.

Source files
------------

// File: rtl/tt_uio_bus_sched_if.sv
// ----------------------------------------------------------------------------
// tt_uio_bus_sched_if
// Bundles the signals between the uio bus scheduler, the two internal write
// requesters and the uio pad pins of the tile.
//
//   master modport : requester/pad side (drives requests, bytes, uio_in, ena)
//   slave  modport : the scheduler
//
//   ena      1  design enable
//   req      2  level request per requester, held for the whole burst
//   wdata0/1 8  write byte from requester 0 / 1
//   wvalid   2  wdataN valid
//   wready   2  byte accepted when wvalid[i] & wready[i]
//   grant    2  one-hot current owner, zero when the bus has no owner
//   uio_out  8  pad output data
//   uio_oe   8  pad output enable, all-ones or all-zeros
//   uio_in   8  pad input data
//   rdata    8  uio_in as last sampled while the bus was idle
//   busy     1  scheduler is not idle
// ----------------------------------------------------------------------------
interface tt_uio_bus_sched_if;
    logic       ena;
    logic [1:0] req;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] wvalid;
    logic [1:0] wready;
    logic [1:0] grant;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uio_in;
    logic [7:0] rdata;
    logic       busy;

    modport master (
        output ena, req, wdata0, wdata1, wvalid, uio_in,
        input  wready, grant, uio_out, uio_oe, rdata, busy
    );

    modport slave (
        input  ena, req, wdata0, wdata1, wvalid, uio_in,
        output wready, grant, uio_out, uio_oe, rdata, busy
    );
endinterface

// File: rtl/tt_uio_bus_sched.sv
// ----------------------------------------------------------------------------
// tt_uio_bus_sched
// Round-robin scheduler for the shared 8-bit bidirectional uio pad bus. Two
// internal write requesters take turns driving the pads; whenever the bus is
// not owned, the pads are tristated and uio_in is sampled into rdata. Every
// release is followed by TURN tristate cycles plus one arbitration cycle, so
// two drivers can never overlap.
//
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    scheduler side of tt_uio_bus_sched_if (see interface header)
//
// Parameters:
//   MAX_HOLD  consecutive OWN cycles allowed while the other side waits (>=2)
//   TURN      tristate turnaround cycles after each release (>=1)
// ----------------------------------------------------------------------------
module tt_uio_bus_sched #(
    parameter int MAX_HOLD = 16,
    parameter int TURN     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_uio_bus_sched_if.slave bus
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_e;

    state_e          state_q,   state_d;
    logic [1:0]      grant_q,   grant_d;
    logic            ptr_q,     ptr_d;      // requester favoured on a tie
    logic [HW-1:0]   hold_q,    hold_d;
    logic [TW-1:0]   turn_q,    turn_d;
    logic [7:0]      uio_out_q, uio_out_d;
    logic            uio_oe_q,  uio_oe_d;
    logic [7:0]      rdata_q,   rdata_d;
    logic [1:0]      wready;

    logic            owner;
    logic            release_now;
    logic [7:0]      owner_wdata;

    // Owner index follows the one-hot grant; only meaningful in OWN.
    assign owner       = grant_q[1];
    assign owner_wdata = owner ? bus.wdata1 : bus.wdata0;

    // Give up the bus when the owner stops asking, the design is disabled, or
    // the hold budget is spent while the other requester is waiting.
    assign release_now = (state_q == ST_OWN) &&
                         (!bus.req[owner] || !bus.ena ||
                          ((hold_q == HOLD_LAST) && bus.req[!owner]));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        uio_out_d = uio_out_q;
        uio_oe_d  = uio_oe_q;
        rdata_d   = rdata_q;
        wready    = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                rdata_d = bus.uio_in;
                if (bus.ena && (bus.req != 2'b00)) begin
                    state_d   = ST_OWN;
                    uio_oe_d  = 1'b1;
                    uio_out_d = 8'h00;
                    hold_d    = '0;
                    if (bus.req == 2'b11) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = bus.req;
                    end
                end
            end

            ST_OWN: begin
                if (release_now) begin
                    state_d   = ST_TURN;
                    grant_d   = 2'b00;
                    uio_oe_d  = 1'b0;
                    uio_out_d = 8'h00;
                    ptr_d     = !owner;
                    turn_d    = '0;
                end else begin
                    // grant_q is one-hot on the owner, so it is the ready mask.
                    wready = grant_q;
                    if (bus.wvalid[owner]) begin
                        uio_out_d = owner_wdata;
                    end
                    // Saturates: a lone requester keeps the bus indefinitely.
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
            hold_q    <= '0;
            turn_q    <= '0;
            uio_out_q <= 8'h00;
            uio_oe_q  <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.wready  = wready;
    assign bus.grant   = grant_q;
    assign bus.uio_out = uio_out_q;
    assign bus.uio_oe  = {8{uio_oe_q}};
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tt_uio_bus_sched.sv
// ----------------------------------------------------------------------------
// tb_tt_uio_bus_sched
// Directed bench for tt_uio_bus_sched (MAX_HOLD=4, TURN=1). Each stimulus step
// drives one cycle of inputs just after the rising edge and pushes the
// hand-computed outputs expected for that cycle; a monitor pops one entry per
// falling edge and compares it with what the scheduler presents.
// ----------------------------------------------------------------------------
module tb_tt_uio_bus_sched;

    typedef struct {
        logic [1:0] grant;
        logic [7:0] oe;
        logic [7:0] out;
        logic [1:0] wready;
        logic [7:0] rdata;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_e;

    tt_uio_bus_sched_if bus ();

    tt_uio_bus_sched #(
        .MAX_HOLD (4),
        .TURN     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the rising edge, queue the expected
    // outputs for this cycle. prst pulses rst_n low for part of the cycle,
    // spanning the falling edge where the monitor samples.
    task automatic step(input logic en, input logic [1:0] rq, input logic [1:0] wv,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] ui,
                        input logic [1:0] g, input logic oe, input logic [7:0] out,
                        input logic [1:0] wr, input logic [7:0] rd, input logic bz,
                        input bit prst);
        exp_t e;
        @(posedge clk);
        #1;
        bus.ena    = en;
        bus.req    = rq;
        bus.wvalid = wv;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
        bus.uio_in = ui;
        e.grant  = g;
        e.oe     = {8{oe}};
        e.out    = out;
        e.wready = wr;
        e.rdata  = rd;
        e.busy   = bz;
        exp_q.push_back(e);
        if (prst) begin
            #1 rst_n = 1'b0;
            #5 rst_n = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("grant",   8'(bus.grant),  8'(mon_e.grant));
            check("uio_oe",  bus.uio_oe,     mon_e.oe);
            check("uio_out", bus.uio_out,    mon_e.out);
            check("wready",  8'(bus.wready), 8'(mon_e.wready));
            check("rdata",   bus.rdata,      mon_e.rdata);
            check("busy",    8'(bus.busy),   8'(mon_e.busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.req    = 2'b00;
        bus.wvalid = 2'b00;
        bus.wdata0 = 8'h00;
        bus.wdata1 = 8'h00;
        bus.uio_in = 8'h00;

        // Reset state, then one idle cycle after release.
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);

        // Requester 0 burst A5, 3C, FF; req drops with wvalid still high.
        step(1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 2'b01, 1, 8'h00, 2'b01, 8'h00, 1, 0);
        step(1, 2'b01, 2'b01, 8'h3C, 8'h00, 8'h00, 2'b01, 1, 8'hA5, 2'b01, 8'h00, 1, 0);
        step(1, 2'b01, 2'b01, 8'hFF, 8'h00, 8'h00, 2'b01, 1, 8'h3C, 2'b01, 8'h00, 1, 0);
        step(1, 2'b00, 2'b01, 8'h77, 8'h00, 8'h00, 2'b01, 1, 8'hFF, 2'b00, 8'h00, 1, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);

        // rdata tracks uio_in in IDLE, freezes while requester 1 owns the bus.
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h5A, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3, 2'b00, 0, 8'h00, 2'b00, 8'h5A, 0, 0);
        step(1, 2'b10, 2'b00, 8'h00, 8'h00, 8'hC3, 2'b00, 0, 8'h00, 2'b00, 8'hC3, 0, 0);
        step(1, 2'b10, 2'b10, 8'h00, 8'h96, 8'h11, 2'b10, 1, 8'h00, 2'b10, 8'hC3, 1, 0);
        step(1, 2'b10, 2'b10, 8'h00, 8'h69, 8'h22, 2'b10, 1, 8'h96, 2'b10, 8'hC3, 1, 0);

        // Partial-cycle reset mid-burst clears everything before the next edge.
        step(1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 1);

        // Tie after reset goes to 0; each side owns 4 cycles, 2-cycle oe gap.
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b01, 1, 8'h00, 2'b01, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b01, 1, 8'hD0, 2'b01, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b01, 1, 8'hD0, 2'b01, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b01, 1, 8'hD0, 2'b00, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b10, 1, 8'h00, 2'b10, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b10, 1, 8'hE1, 2'b10, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b10, 1, 8'hE1, 2'b10, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b10, 1, 8'hE1, 2'b00, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b11, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        // Requester 0 again; it drops req in its first OWN cycle.
        step(1, 2'b10, 2'b11, 8'hD0, 8'hE1, 8'h00, 2'b01, 1, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);

        // Lone requester 1 for 40 cycles: hold saturates, grant never drops.
        for (int i = 0; i < 40; i++) begin
            step(1, 2'b10, 2'b10, 8'h00, 8'(i * 7 + 1), 8'h00, 2'b10, 1,
                 (i == 0) ? 8'h00 : 8'((i - 1) * 7 + 1), 2'b10, 8'h00, 1, 0);
        end

        // ena low mid-OWN: no accept that cycle, release, no regrant while low.
        step(0, 2'b11, 2'b10, 8'h00, 8'hAB, 8'h00, 2'b10, 1, 8'h12, 2'b00, 8'h00, 1, 0);
        step(0, 2'b11, 2'b11, 8'h00, 8'hAB, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(0, 2'b11, 2'b11, 8'h00, 8'hAB, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(0, 2'b11, 2'b11, 8'h00, 8'hAB, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(0, 2'b11, 2'b11, 8'h00, 8'hAB, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        // ena back: tie now favours requester 0, which releases right away.
        step(1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b01, 1, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 1, 0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 8'h00, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drain", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
